// File: rtl/ret_addr_stack.sv
// ret_addr_stack: LIFO return-address stack that sits beside the program counter.
// A successful pop shows up one cycle later on pop_addr with a single-cycle
// pop_valid pulse. Sticky overflow/underflow flags go to the control unit.
// Optional feature macro: RAS_CIRCULAR_EN. When it is defined, a push on a full
// stack overwrites the oldest entry instead of being dropped.
module ret_addr_stack #(
    parameter int  WIDTH = 5,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pop_addr,
    output logic             pop_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage and the pointer to the current top entry. Because DEPTH is
    // a power of two, pointer arithmetic wraps modulo DEPTH on its own.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    tos_q, tos_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pop_addr_q, pop_addr_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Next-state decode for pointer, count, pop output, flags and the entry write.
    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        pop_addr_d  = pop_addr_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        mem_we      = 1'b0;
        mem_waddr   = tos_q;

        unique case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    mem_we    = 1'b1;
                    mem_waddr = tos_q + PW'(1);
                    tos_d     = tos_q + PW'(1);
                    count_d   = count_q + CW'(1);
                end else begin
`ifdef RAS_CIRCULAR_EN
                    // The slot above the top is the oldest entry when full,
                    // so writing there evicts it and keeps count at DEPTH.
                    mem_we    = 1'b1;
                    mem_waddr = tos_q + PW'(1);
                    tos_d     = tos_q + PW'(1);
`else
                    overflow_d = 1'b1;
`endif
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    pop_addr_d  = mem_q[tos_q];
                    pop_valid_d = 1'b1;
                    tos_d       = tos_q - PW'(1);
                    count_d     = count_q - CW'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            2'b11: begin
                pop_valid_d = 1'b1;
                if (!is_empty) begin
                    // Return the old top and replace it in place.
                    pop_addr_d = mem_q[tos_q];
                    mem_we     = 1'b1;
                    mem_waddr  = tos_q;
                end else begin
                    // Nothing stored: the pushed address passes straight through.
                    pop_addr_d = push_addr;
                end
            end
            default: ;
        endcase
    end

    // Control and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q       <= '1;
            count_q     <= '0;
            pop_addr_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            pop_addr_q  <= pop_addr_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // One write port per entry; contents are left as-is on reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst && mem_we && (mem_waddr == PW'(gi))) begin
                mem_q[gi] <= push_addr;
            end
        end
    end

    assign pop_addr  = pop_addr_q;
    assign pop_valid = pop_valid_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Testbench for ret_addr_stack: directed sequences followed by random traffic.
// The driver updates a queue-based reference stack and pushes the expected
// post-edge outputs into a scoreboard; a monitor compares them after each edge.
module tb_ret_addr_stack;

    localparam int WIDTH = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic [WIDTH-1:0] push_addr;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] pop_addr;
    logic             pop_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    ret_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .clr_err   (clr_err),
        .pop_addr  (pop_addr),
        .pop_valid (pop_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] a;
        int               cnt;
        logic             e;
        logic             f;
        logic             o;
        logic             u;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model: a queue with the bottom entry at index 0.
    int               stk[$];
    logic [WIDTH-1:0] m_addr = '0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs and record what the DUT must show after the edge.
    task automatic cyc(input logic r, input logic p, input logic [WIDTH-1:0] a,
                       input logic q, input logic c);
        exp_t x;
        @(negedge clk);
        rst = r; push = p; push_addr = a; pop = q; clr_err = c;
        x.v = 1'b0;
        if (r) begin
            stk.delete();
            m_addr = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (c) begin
                m_ovf = 1'b0; m_unf = 1'b0;
            end
            if (p && q) begin
                x.v = 1'b1;
                if (stk.size() == 0) begin
                    m_addr = a;
                end else begin
                    m_addr = WIDTH'(stk[stk.size()-1]);
                    stk[stk.size()-1] = int'(a);
                end
            end else if (p) begin
                if (stk.size() < DEPTH) begin
                    stk.push_back(int'(a));
                end else begin
`ifdef RAS_CIRCULAR_EN
                    void'(stk.pop_front());
                    stk.push_back(int'(a));
`else
                    m_ovf = 1'b1;
`endif
                end
            end else if (q) begin
                if (stk.size() > 0) begin
                    x.v = 1'b1;
                    m_addr = WIDTH'(stk.pop_back());
                end else begin
                    m_unf = 1'b1;
                end
            end
        end
        x.a   = m_addr;
        x.cnt = stk.size();
        x.e   = (stk.size() == 0);
        x.f   = (stk.size() == DEPTH);
        x.o   = m_ovf;
        x.u   = m_unf;
        exp_q.push_back(x);
    endtask

    // Monitor: compare every observed cycle against the oldest expectation.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("pop_valid", int'(pop_valid), int'(x.v));
            chk("pop_addr",  int'(pop_addr),  int'(x.a));
            chk("count",     int'(count),     x.cnt);
            chk("empty",     int'(empty),     int'(x.e));
            chk("full",      int'(full),      int'(x.f));
            chk("overflow",  int'(overflow),  int'(x.o));
            chk("underflow", int'(underflow), int'(x.u));
            if (pop_valid)
                $display("[TB] t=%0t pop addr=%0h count=%0d ovf=%0b unf=%0b",
                         $time, pop_addr, count, overflow, underflow);
        end
    end

    initial begin
        rst = 1'b1; push = 1'b0; push_addr = '0; pop = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);

        // Reset and idle.
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Basic LIFO order.
        cyc(0, 1, 5'h03, 0, 0);
        cyc(0, 1, 5'h07, 0, 0);
        cyc(0, 1, 5'h0A, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Fill past capacity, then drain.
        for (int i = 1; i <= 5; i++) cyc(0, 1, WIDTH'(i), 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);

        // Underflow, clear, and clear colliding with a new error.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);

        // Simultaneous push/pop with data and on empty.
        cyc(0, 1, 5'h11, 0, 0);
        cyc(0, 1, 5'h15, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 5'h1F, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Push/pop on a full stack leaves the flags alone.
        for (int i = 0; i < 4; i++) cyc(0, 1, WIDTH'(5'h18 + i), 0, 0);
        cyc(0, 1, 5'h09, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Reset arriving together with a pop.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 5'h02, 0, 0);
        cyc(0, 1, 5'h04, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 99) < 55),
                WIDTH'($urandom),
                ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 8));
        end
        cyc(0, 0, 0, 0, 0);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
